regfile_rename: RTL

//  Parametrised architectural register file with per-register rename status (valid + ROB tag).

---
 rtl/regfile_rename.sv | 126 ++++++++++++
 1 files changed

// File: rtl/regfile_rename.sv
// rtl/regfile_rename.sv - rename-aware architectural register file (optional REGFILE_RENAME_BYPASS_EN)
module regfile_rename #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int AW     = 5,
   parameter int TAG_W  = 3,
   parameter int NUM_RD = 2,
   parameter int NUM_WB = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     alloc,
   input  logic [AW-1:0]            alloc_rd,
   input  logic [TAG_W-1:0]         alloc_tag,
   input  logic [NUM_WB-1:0]        wb_valid,
   input  logic [NUM_WB*AW-1:0]     wb_rd,
   input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
   input  logic [NUM_WB*DATA_W-1:0] wb_data,
   input  logic [NUM_RD*AW-1:0]     rd_src,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_ready,
   output logic [NUM_RD*TAG_W-1:0]  rd_tag,
   input  logic [AW-1:0]            dbg_src,
   output logic [DATA_W-1:0]        dbg_data,
   output logic [AW:0]              pend_cnt
);

   logic [DATA_W-1:0] r_data [NREG];
   logic [TAG_W-1:0]  r_tag  [NREG];
   logic [NREG-1:0]   r_valid;
   logic [AW:0]       r_pend_cnt;

   logic [NREG-1:0]   w_wb_hit;
   logic [NREG-1:0]   w_wb_match;
   logic [NREG-1:0]   w_alloc_hit;
   logic [DATA_W-1:0] w_wb_dat [NREG];
   logic [AW:0]       w_ready_cnt;
   logic              w_alloc_new;

   // Per register: pick the winning write-back port (highest index scanned last) and the allocate hit
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         w_wb_hit[i]    = 1'b0;
         w_wb_match[i]  = 1'b0;
         w_wb_dat[i]    = '0;
         w_alloc_hit[i] = 1'b0;
         for (int k = 0; k < NUM_WB; k++) begin
            if (i != 0 && wb_valid[k] && wb_rd[k*AW +: AW] == AW'(i)) begin
               w_wb_hit[i]   = 1'b1;
               w_wb_dat[i]   = wb_data[k*DATA_W +: DATA_W];
               w_wb_match[i] = !r_valid[i] && (r_tag[i] == wb_tag[k*TAG_W +: TAG_W]);
            end
         end
         w_alloc_hit[i] = (i != 0) && alloc && !flush && (alloc_rd == AW'(i));
      end
   end

   // Pending-count delta: one allocate may newly pend a register, each surviving tag match readies one
   always_comb begin
      w_ready_cnt = '0;
      w_alloc_new = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         if (w_wb_match[i] && !w_alloc_hit[i])
            w_ready_cnt = w_ready_cnt + (AW+1)'(1);
         if (w_alloc_hit[i] && r_valid[i])
            w_alloc_new = 1'b1;
      end
   end

   // State update: data always takes write-back; flush beats allocate beats readying
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_data[i] <= '0;
            r_tag[i]  <= '0;
         end
         r_valid    <= '1;
         r_pend_cnt <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (w_wb_hit[i])
               r_data[i] <= w_wb_dat[i];
            if (flush) begin
               r_valid[i] <= 1'b1;
               r_tag[i]   <= '0;
            end else if (w_alloc_hit[i]) begin
               r_valid[i] <= 1'b0;
               r_tag[i]   <= alloc_tag;
            end else if (w_wb_match[i]) begin
               r_valid[i] <= 1'b1;
            end
         end
         if (flush)
            r_pend_cnt <= '0;
         else
            r_pend_cnt <= r_pend_cnt + (AW+1)'(w_alloc_new) - w_ready_cnt;
      end
   end

   // Operand reads from registered state, optionally forwarding a write-back that readies the source
   always_comb begin
      rd_data  = '0;
      rd_ready = '0;
      rd_tag   = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         if (rd_src[p*AW +: AW] != '0) begin
            rd_data[p*DATA_W +: DATA_W] = r_data[rd_src[p*AW +: AW]];
            rd_ready[p]                 = r_valid[rd_src[p*AW +: AW]];
            rd_tag[p*TAG_W +: TAG_W]    = r_tag[rd_src[p*AW +: AW]];
`ifdef REGFILE_RENAME_BYPASS_EN
            if (w_wb_match[rd_src[p*AW +: AW]]) begin
               rd_data[p*DATA_W +: DATA_W] = w_wb_dat[rd_src[p*AW +: AW]];
               rd_ready[p]                 = 1'b1;
            end
`endif
         end else begin
            rd_ready[p] = 1'b1;
         end
      end
   end

   assign dbg_data = r_data[dbg_src];
   assign pend_cnt = r_pend_cnt;

endmodule
